// File: rtl/klein_pkg.sv
// Shared definitions for the KLEIN serialised S-box engine.
//   state_t      : engine FSM states
//   NIBBLES      : nibbles per 64-bit word
//   SBOX_TABLE   : KLEIN S-box, entry i lives in bits [4i+3:4i]
//   REQ_STATE/REQ_KEY : requester ids (cipher state / key schedule)
//   sbox_lookup  : table lookup helper
package klein_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLES = 16;

  // 0..F -> 7,4,A,9,1,F,B,0,C,3,2,6,8,E,D,5 (entry 0 in the low nibble).
  localparam logic [63:0] SBOX_TABLE = 64'h5DE8_623C_0BF1_9A47;

  localparam logic REQ_STATE = 1'b0;
  localparam logic REQ_KEY   = 1'b1;

  function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/klein_sbox.sv
// KLEIN 4-bit S-box, purely combinational. The mapping is an involution,
// so the same instance serves encryption and decryption.
//   din  : 4-bit input nibble
//   dout : substituted nibble
module klein_sbox
  import klein_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = sbox_lookup(din);

endmodule

// File: rtl/klein_sbox_sched.sv
// Serialised S-box engine shared by two requesters under round-robin
// arbitration. One klein_sbox instance walks the 16 nibbles of a word,
// MSB nibble first, substituting nibble i only where mask[i] is set.
//   clk, rst_n             : clock, synchronous active-low reset
//   req0_*                 : cipher-state requester (valid/ready/data/mask)
//   req1_*                 : key-schedule requester (valid/ready/data/mask)
//   resp_valid/resp_ready  : result handshake
//   resp_data, resp_id     : substituted word and owning requester
//   busy                   : high while a job is in BUSY or DONE
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high. reqX_ready is a combinational function of the valids and is
// only high in IDLE, so a requester must not wait for ready before raising
// valid. resp_valid stays high, with resp_data/resp_id stable, until the
// edge where resp_ready is also high.
module klein_sbox_sched
  import klein_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic [DATA_W/4-1:0] req0_mask,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req1_data,
  input  logic [DATA_W/4-1:0] req1_mask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_id,
  output logic                busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  last_grant;
  logic [DATA_W-1:0]     work;
  logic [DATA_W/4-1:0]   mask_q;
  logic                  id_q;
  logic                  grant0;
  logic                  grant1;
  logic [3:0]            sbox_in;
  logic [3:0]            sbox_out;

  assign sbox_in = work[{cnt, 2'b00} +: 4];

  klein_sbox u_sbox (
    .din  (sbox_in),
    .dout (sbox_out)
  );

  // Arbitration and next state. With both valids high the requester that
  // did not win last time gets the grant.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nxt  = state;
    case (state)
      IDLE: begin
        grant0     = req0_valid & (~req1_valid | (last_grant == REQ_KEY));
        grant1     = req1_valid & (~req0_valid | (last_grant == REQ_STATE));
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 | grant1) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '1;
      last_grant <= REQ_KEY;
      work       <= '0;
      mask_q     <= '0;
      id_q       <= REQ_STATE;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant0) begin
            work       <= req0_data;
            mask_q     <= req0_mask;
            id_q       <= REQ_STATE;
            last_grant <= REQ_STATE;
            cnt        <= '1;
          end else if (grant1) begin
            work       <= req1_data;
            mask_q     <= req1_mask;
            id_q       <= REQ_KEY;
            last_grant <= REQ_KEY;
            cnt        <= '1;
          end
        end
        BUSY: begin
          work[{cnt, 2'b00} +: 4] <= mask_q[cnt] ? sbox_out : sbox_in;
          // Stop at zero: the final nibble cycle must not start a new pass.
          if (cnt != '0) cnt <= cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == DONE);
  assign resp_data  = work;
  assign resp_id    = id_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_klein_sbox_sched.sv
module tb_klein_sbox_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req0_data;
  logic [15:0] req0_mask;
  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] req1_data;
  logic [15:0] req1_mask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {id, data}.
  logic [64:0] exp_q[$];

  klein_sbox_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_mask  (req0_mask),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_mask  (req1_mask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Raises valid, waits for ready, consumes the accept edge, drops valid.
  // Returns at accept edge + 1 time unit; waited = idle cycles before accept.
  task automatic start_job(input int which, input logic [63:0] d, input logic [15:0] m,
                           output int waited);
    logic rdy;
    if (which == 0) begin
      req0_valid = 1'b1; req0_data = d; req0_mask = m;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_mask = m;
    end
    waited = 0;
    #1;
    rdy = (which == 0) ? req0_ready : req1_ready;
    while (!rdy && waited < 40) begin
      @(posedge clk); #1;
      waited++;
      rdy = (which == 0) ? req0_ready : req1_ready;
    end
    if (!rdy) check("accept_timeout", 65'(rdy), 65'(1));
    check("ready_excl", 65'(req0_ready & req1_ready), 65'(0));
    @(posedge clk); #1;
    if (which == 0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  // Waits for the result, checks latency from accept and the scoreboard
  // entry, then completes the response handshake.
  task automatic finish_job(input string tag);
    int lat;
    logic [64:0] exp;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 65'(lat), 65'(16));
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 65'h0;
    check({tag, "_resp"}, {resp_id, resp_data}, exp);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "_released"}, 65'(resp_valid), 65'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int lat;
    logic seen;
    logic [63:0] held;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_mask = '0;
    req1_valid = 1'b0; req1_data = '0; req1_mask = '0;
    resp_ready = 1'b0;

    do_reset();
    check("rst_valid", 65'(resp_valid), 65'(0));
    check("rst_data",  65'(resp_data),  65'(0));
    check("rst_id",    65'(resp_id),    65'(0));
    check("rst_busy",  65'(busy),       65'(0));
    check("rst_ready", 65'({req0_ready, req1_ready}), 65'(0));

    // Full substitution: S(0)=7 everywhere.
    start_job(0, 64'h0000000000000000, 16'hFFFF, w);
    check("full_busy", 65'(busy), 65'(1));
    exp_q.push_back({1'b0, 64'h7777777777777777});
    finish_job("full");

    // Involution: S(7)=0.
    start_job(0, 64'h7777777777777777, 16'hFFFF, w);
    exp_q.push_back({1'b0, 64'h0000000000000000});
    finish_job("invol");

    // Masked key path: nibbles 7..4 = 8,9,A,B -> C,3,2,6.
    start_job(1, 64'h0123456789ABCDEF, 16'h00F0, w);
    exp_q.push_back({1'b1, 64'h01234567C326CDEF});
    finish_job("masked");

    // Fairness from reset with both valids held; req1 uses mask 0.
    do_reset();
    req0_data = 64'h0; req0_mask = 16'hFFFF;
    req1_data = 64'h0123456789ABCDEF; req1_mask = 16'h0000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      w = 0;
      #1;
      while (!(req0_ready | req1_ready) && w < 40) begin
        @(posedge clk); #1;
        w++;
      end
      check("fair_excl", 65'(req0_ready & req1_ready), 65'(0));
      check("fair_grant", 65'(req1_ready), 65'(j % 2));
      if (j % 2 == 0) exp_q.push_back({1'b0, 64'h7777777777777777});
      else            exp_q.push_back({1'b1, 64'h0123456789ABCDEF});
      @(posedge clk); #1;
      check("fair_busy_ready", 65'({req0_ready, req1_ready}), 65'(0));
      finish_job("fair");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // req0 alone twice -> granted both times.
    for (int j = 0; j < 2; j++) begin
      start_job(0, 64'hFEDCBA9876543210, 16'hFFFF, w);
      exp_q.push_back({1'b0, 64'h5DE8623C0BF19A47});
      finish_job("solo0");
    end

    // Backpressure: hold resp_ready low for 5 cycles in DONE.
    start_job(0, 64'h0123456789ABCDEF, 16'hFFFF, w);
    exp_q.push_back({1'b0, 64'h74A91FB0C3268ED5});
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 65'(lat), 65'(16));
    held = resp_data;
    req1_valid = 1'b1; req1_data = 64'h7777777777777777; req1_mask = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_valid", 65'(resp_valid), 65'(1));
      check("bp_data",  65'(resp_data),  65'(64'h74A91FB0C3268ED5));
      check("bp_ready", 65'({req0_ready, req1_ready}), 65'(0));
    end
    check("bp_stable", 65'(resp_data), 65'(held));
    check("bp_resp", {resp_id, resp_data}, exp_q.pop_front());
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp_idle_busy",  65'(busy),       65'(0));
    check("bp_idle_valid", 65'(resp_valid), 65'(0));
    check("bp_idle_ready", 65'(req1_ready), 65'(1));
    start_job(1, 64'h7777777777777777, 16'hFFFF, w);
    check("bp_next_wait", 65'(w), 65'(0));
    check("bp_next_busy", 65'(busy), 65'(1));
    exp_q.push_back({1'b1, 64'h0000000000000000});
    finish_job("bp_next");

    // Reset in the middle of a job, while nibble 8 is being processed.
    start_job(0, 64'h0123456789ABCDEF, 16'hFFFF, w);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_busy",  65'(busy),       65'(0));
    check("mid_rst_valid", 65'(resp_valid), 65'(0));
    check("mid_rst_data",  65'(resp_data),  65'(0));
    seen = 1'b0;
    repeat (24) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    check("mid_rst_dropped", 65'(seen), 65'(0));
    start_job(1, 64'h0123456789ABCDEF, 16'h00F0, w);
    exp_q.push_back({1'b1, 64'h01234567C326CDEF});
    finish_job("post_rst");

    check("sb_empty", 65'(exp_q.size()), 65'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/klein_sbox_sched.md
Name: klein_sbox_sched

Overview:
- Shared, serialised S-box engine for the KLEIN datapath. One 4-bit sbox instance is time-multiplexed over the 16 nibbles of a 64-bit word, one nibble per cycle.
- Two requesters share the engine under round-robin arbitration:
  - requester 0: cipher state (full substitution);
  - requester 1: key schedule (partial, masked substitution).
- Replaces a fully parallel 16-sbox substitution where area matters. The KLEIN S-box is an involution, so the same engine serves encryption and decryption.

Parameters:
- DATA_W, 64, word width; fixed at 64 (16 nibbles). Other values are unsupported.
- CNT_W, 4, nibble counter width; log2(DATA_W/4).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- req0_valid  in  1  requester 0 has a word
- req0_ready  out  1  requester 0 word accepted this cycle
- req0_data  in  64  requester 0 word
- req0_mask  in  16  bit i=1 -> substitute nibble i (data[4i+3:4i])
- req1_valid  in  1  requester 1 has a word
- req1_ready  out  1  requester 1 word accepted this cycle
- req1_data  in  64  requester 1 word
- req1_mask  in  16  as req0_mask
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  64  substituted word
- resp_id  out  1  requester that owns resp_data
- busy  out  1  high in BUSY or DONE

Behaviour:
- States:
  - IDLE -> BUSY on an accept.
  - BUSY -> DONE after 16 nibble cycles.
  - DONE -> IDLE when resp_valid & resp_ready.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; resp_valid=0; resp_data=0; resp_id=0; busy=0.
  - Counter=15; last_grant=1, so requester 0 wins first.
  - Any in-flight word is discarded; no response is produced for it.
- Arbitration (IDLE only, combinational from the valids):
  - Exactly one valid -> that requester is granted.
  - Both valid -> grant the requester not equal to last_grant.
  - reqX_ready = (state==IDLE) & grant_X. Both readies are low in BUSY and DONE.
  - Ready depends on the valids; the requesters must not derive valid from ready.
- Accept edge (valid & ready):
  - Capture data, mask and id into internal registers.
  - Set last_grant=id, counter=15, go to BUSY.
  - The requester may change its inputs afterwards.
- BUSY, per cycle:
  - Nibble n=counter goes through the single sbox.
  - Register nibble n <= mask[n] ? S(nibble) : nibble.
  - counter decrements, MSB nibble first.
  - On the cycle with counter==0, write the last nibble and go to DONE. The counter does not wrap into a new pass.
- Latency: resp_valid rises exactly 16 clock edges after the accept edge, independent of mask.
  - mask=0 still takes 16 cycles and returns the data unchanged.
- DONE:
  - resp_valid=1; resp_data and resp_id are held stable until the handshake.
  - resp_ready low indefinitely -> hold, accept nothing new.
  - On the handshake edge: resp_valid=0, return to IDLE. A new word can be accepted on the very next edge, so there is one bubble cycle minimum between jobs.
- resp_ready in IDLE/BUSY: ignored.
- resp_data after the handshake: holds its last value; don't-care while resp_valid=0.
- S-box table, input 0..F -> output: 7,4,A,9,1,F,B,0,C,3,2,6,8,E,D,5.

Decomposition:
- Shared package klein_pkg:
  - state enum {IDLE, BUSY, DONE};
  - NIBBLES=16;
  - S-box table constant;
  - requester id constants REQ_STATE=0, REQ_KEY=1.
- Sub-module: the existing 4-bit sbox module, instantiated once.
- Arbiter stays inline; a separate module is not warranted.

Test Plan:
- Full substitution: req0 data 64'h0000000000000000, mask 16'hFFFF.
  -> resp_data 64'h7777777777777777, resp_id 0, resp_valid 16 edges after accept.
- Involution: feed 64'h7777777777777777, mask FFFF, via req0.
  -> resp_data 64'h0000000000000000.
- Masked key path: req1 data 64'h0123456789ABCDEF, mask 16'h00F0.
  -> resp_data 64'h01234567C326CDEF, resp_id 1.
- Fairness:
  - both valids held from reset -> grants go 0,1,0,1 across four jobs;
  - readies are never both high; req0 alone twice -> 0,0.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE.
  - resp_valid stays 1, resp_data stable, both readies 0.
  - Handshake on cycle 6 -> IDLE, next accept one edge later.
- Reset mid-operation: assert rst_n=0 at nibble 8 of a job.
  - Next edge: IDLE, resp_valid 0, busy 0; the job is dropped.
  - A following req1-only job completes normally.
